fifo_burst_reader: RTL

- Read-side consumer for the team's same-clock FIFO. Drains a programmed number of words from the FIFO's nempty/re/data port and emits them as an AXI-style write-data burst (wdata/wvalid/wready/wlast).
- Sits between a FIFO filled by a producer and the AXI write-data channel of the memory controller.
- Handles backpressure on both sides with a single registered output stage, so full throughput is one beat per clock.

---
 rtl/fifo_burst_reader_pkg.sv | 16 +
 rtl/fifo_burst_reader_if.sv | 40 ++++
 rtl/fifo_same_clock.sv | 69 ++++++
 rtl/fifo_burst_reader.sv | 103 ++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// fifo_burst_reader_pkg
//   Shared definitions for the FIFO-to-burst reader slice.
//   - state_t : FSM encoding for the reader (IDLE / BURST / DRAIN)
//   - default widths used by the interface and the top module
package fifo_burst_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_LEN_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if
//   Bundles the control, FIFO read-port and write-data burst signals of the
//   burst reader.
//   - start/len/busy/done      : burst request and status
//   - fifo_nempty/fifo_data/re : show-ahead FIFO read port
//   - wdata/wvalid/wready/wlast: AXI-style write-data channel
//   modport master : the reader itself
//   modport slave  : whoever surrounds the reader (controller, FIFO, sink)
interface fifo_burst_reader_if
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
);

  logic                  start;
  logic [LEN_WIDTH-1:0]  len;
  logic                  busy;
  logic                  done;

  logic                  fifo_nempty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_re;

  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  wlast;

  modport master (
    input  start, len, fifo_nempty, fifo_data, wready,
    output busy, done, fifo_re, wdata, wvalid, wlast
  );

  modport slave (
    output start, len, fifo_nempty, fifo_data, wready,
    input  busy, done, fifo_re, wdata, wvalid, wlast
  );

endinterface

// File: rtl/fifo_same_clock.sv
// fifo_same_clock
//   Single-clock show-ahead FIFO: dout is valid whenever nempty=1, and
//   asserting re for one cycle consumes that word.
//   Ports:
//     clk, rst_n : clock and asynchronous active-low reset
//     we, din    : push (ignored while full)
//     full       : no room for another word
//     re         : pop (ignored while empty)
//     dout       : head word
//     nempty     : head word valid
//     count      : number of stored words
module fifo_same_clock #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  nempty,
  output logic [ADDR_WIDTH:0]   count
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  do_write;
  logic                  do_read;

  assign do_write = we & ~full;
  assign do_read  = re & nempty;

  // count never exceeds 2**ADDR_WIDTH, so its MSB alone means full
  assign full   = count_r[ADDR_WIDTH];
  assign nempty = (count_r != '0);
  assign dout   = mem[rd_ptr];
  assign count  = count_r;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_write && !do_read) begin
        count_r <= count_r + 1'b1;
      end else if (!do_write && do_read) begin
        count_r <= count_r - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Drains len+1 words from a show-ahead FIFO and emits them as an AXI-style
//   write-data burst through a single registered output stage, sustaining
//   one beat per clock while the FIFO has data and the sink is ready.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous reset, active low (abandons any burst in flight)
//     bus   : fifo_burst_reader_if.master
//             start/len in, busy/done out,
//             fifo_nempty/fifo_data in, fifo_re out (combinational),
//             wdata/wvalid/wlast out (registered), wready in
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_burst_reader_if.master bus
);

  state_t                state;
  logic [LEN_WIDTH-1:0]  len_r;
  // one bit wider than len so a full 2**LEN_WIDTH burst never wraps
  logic [LEN_WIDTH:0]    load_cnt;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  wvalid_r;
  logic                  wlast_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  ld;
  logic                  last_load;

  // The output register may take a new word when it is empty or its current
  // beat is being accepted this cycle; that overlap gives full throughput.
  assign ld        = (state == BURST) & bus.fifo_nempty & (~wvalid_r | bus.wready);
  assign last_load = (load_cnt == {1'b0, len_r});

  assign bus.fifo_re = ld;
  assign bus.wdata   = wdata_r;
  assign bus.wvalid  = wvalid_r;
  assign bus.wlast   = wlast_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

  // Reader FSM with registered outputs. start is only looked at in IDLE, so a
  // request during a burst (including its final accept cycle) is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_r    <= '0;
      load_cnt <= '0;
      wdata_r  <= '0;
      wvalid_r <= 1'b0;
      wlast_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_r    <= bus.len;
            load_cnt <= '0;
            busy_r   <= 1'b1;
            state    <= BURST;
          end
        end

        BURST: begin
          if (ld) begin
            wdata_r  <= bus.fifo_data;
            wvalid_r <= 1'b1;
            wlast_r  <= last_load;
            load_cnt <= load_cnt + {{LEN_WIDTH{1'b0}}, 1'b1};
            if (last_load) begin
              state <= DRAIN;
            end
          end else if (wvalid_r && bus.wready) begin
            wvalid_r <= 1'b0;
            wlast_r  <= 1'b0;
          end
        end

        DRAIN: begin
          if (wvalid_r && bus.wready && wlast_r) begin
            wvalid_r <= 1'b0;
            wlast_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
